// File: rtl/uart_pkg.sv
// Definitions shared by the UART receive and transmit ends: state encodings,
// default timing constants and a helper that sizes the counters.
package uart_pkg;

    // 100 MHz sys_clk, 9600 baud, 8x oversampling
    localparam int UART_N      = 1302;
    localparam int UART_SAMPLE = 8;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // Bits needed to count 0..limit-1, never less than one
    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/uart_sample_tick.sv
// Oversample tick generator: counts 0..N-1 and pulses tick on the terminal count.
// Shared by the RX and TX ends of the UART.
module uart_sample_tick
    import uart_pkg::*;
#(
    parameter int N = UART_N
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int             CW   = cnt_width(N);
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    logic [CW-1:0] count;

    assign tick = enable && (count == LAST);

    always_ff @(posedge sys_clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_top.sv
// 8N1 UART receiver: synchronises rx, finds the start edge, samples each bit at
// its centre and reports a good byte (rx_valid) or a bad stop bit (frame_err).
//
// state    | meaning
// ---------|--------------------------------------------------------------
// RX_IDLE  | line idle, waiting for a high-to-low edge on rx
// RX_START | counting to the middle of the start bit, reject if high there
// RX_DATA  | sampling data bits 0..7 once per bit period, LSB first
// RX_STOP  | sampling the stop bit; high -> byte out, low -> framing error
module uart_rx_top
    import uart_pkg::*;
#(
    parameter int N      = UART_N,
    parameter int SAMPLE = UART_SAMPLE
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int            TW     = cnt_width(SAMPLE);
    localparam logic [TW-1:0] T_HALF = TW'(SAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(SAMPLE - 1);

    logic rx_m, rx_s, rx_p;

    rx_state_t     state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          tick;
    logic          tick_clear;

    // Idle-high reset so a quiet line never looks like a start edge
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_p <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_p <= rx_s;
        end
    end

    // Restarting the tick phase on each state change keeps samples bit-centred
    assign tick_clear = (state_q == RX_IDLE) || (state_d != state_q);

    uart_sample_tick #(
        .N (N)
    ) u_tick (
        .sys_clk (sys_clk),
        .rst     (rst),
        .clear   (tick_clear),
        .enable  (busy),
        .tick    (tick)
    );

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            RX_IDLE: begin
                if (rx_p && !rx_s) state_d = RX_START;
            end
            RX_START: begin
                if (tick) begin
                    if (tcnt_q == T_HALF) state_d = rx_s ? RX_IDLE : RX_DATA;
                    else                  tcnt_d  = tcnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (tcnt_q == T_FULL) begin
                        shift_d[idx_q] = rx_s;
                        tcnt_d         = '0;
                        idx_d          = idx_q + 1'b1;
                        if (idx_q == 3'd7) state_d = RX_STOP;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    if (tcnt_q == T_FULL) begin
                        state_d = RX_IDLE;
                        if (rx_s) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase

        if (state_d != state_q) begin
            tcnt_d = '0;
            idx_d  = '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= RX_IDLE;
            tcnt_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data_out  = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_top.sv
// Directed bench for uart_rx_top at N=4, SAMPLE=8 (one bit = 32 sys_clk cycles).
module tb_uart_rx_top;

    localparam int N      = 4;
    localparam int SAMPLE = 8;
    localparam int BIT    = N * SAMPLE;
    // falling edge to pulse: 3 sync/detect cycles + 9.5 bit times
    localparam int LAT    = 3 + (19 * BIT) / 2;

    logic       sys_clk = 1'b0;
    logic       rst     = 1'b1;
    logic       rx      = 1'b1;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    int         cyc      = 0;
    int         t0_cyc   = 0;
    int         lat      = -1;
    bit         lat_set  = 1'b0;
    int         valid_hi = 0;
    int         ferr_hi  = 0;
    int         both_hi  = 0;
    logic [7:0] got_q[$];

    uart_rx_top #(
        .N      (N),
        .SAMPLE (SAMPLE)
    ) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .rx        (rx),
        .data_out  (data_out),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc++;

    always @(negedge sys_clk) begin
        if (rx_valid) begin
            valid_hi++;
            got_q.push_back(data_out);
            if (!lat_set) begin
                lat     = cyc - t0_cyc;
                lat_set = 1'b1;
            end
        end
        if (frame_err) ferr_hi++;
        if (rx_valid && frame_err) both_hi++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives a 10-bit frame {stop, data, start} LSB first for the given number of
    // cycles; call on a negedge. rx is left at the last driven level.
    task automatic drive_frame(input logic [9:0] fr, input int cycles);
        t0_cyc  = cyc;
        lat_set = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            rx = fr[i / BIT];
            @(negedge sys_clk);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         v0, f0, base;
        logic [8:0] b0, b1;

        repeat (5) @(negedge sys_clk);
        check("rst_data",  data_out,  8'h00);
        check("rst_valid", rx_valid,  1'b0);
        check("rst_ferr",  frame_err, 1'b0);
        check("rst_busy",  busy,      1'b0);
        rst = 1'b0;
        repeat (10) @(negedge sys_clk);

        // Good frame 0xA5
        v0 = valid_hi; f0 = ferr_hi;
        drive_frame({1'b1, 8'hA5, 1'b0}, 10 * BIT);
        repeat (4) @(negedge sys_clk);
        check("a5_data",    data_out,      8'hA5);
        check("a5_vcycles", valid_hi - v0, 1);
        check("a5_ferr",    ferr_hi - f0,  0);
        check("a5_latency", (lat >= LAT - N) && (lat <= LAT + N), 1'b1);
        check("a5_busy",    busy,          1'b0);

        // Start glitch: low for 2 ticks, then high
        v0 = valid_hi; f0 = ferr_hi;
        rx = 1'b0;
        repeat (5) @(negedge sys_clk);
        check("glitch_busy_hi", busy, 1'b1);
        repeat (2 * N - 5) @(negedge sys_clk);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge sys_clk);
        check("glitch_valid", valid_hi - v0, 0);
        check("glitch_ferr",  ferr_hi - f0,  0);
        check("glitch_data",  data_out,      8'hA5);
        check("glitch_busy",  busy,          1'b0);

        // Bad stop bit on 0x3C, line then held low
        v0 = valid_hi; f0 = ferr_hi;
        drive_frame({1'b0, 8'h3C, 1'b0}, 10 * BIT);
        repeat (3 * BIT) @(negedge sys_clk);
        check("ferr_cycles", ferr_hi - f0,  1);
        check("ferr_valid",  valid_hi - v0, 0);
        check("ferr_data",   data_out,      8'hA5);
        check("ferr_busy",   busy,          1'b0);
        rx = 1'b1;
        repeat (BIT) @(negedge sys_clk);

        // Back-to-back 0x00 then 0xFF; next start just past mid stop bit
        // (a few cycles later to cover the synchroniser delay)
        base = got_q.size(); f0 = ferr_hi;
        drive_frame({1'b1, 8'h00, 1'b0}, 9 * BIT + BIT / 2 + 4);
        drive_frame({1'b1, 8'hFF, 1'b0}, 10 * BIT);
        repeat (BIT) @(negedge sys_clk);
        b0 = (got_q.size() > base)     ? {1'b0, got_q[base]}     : 9'h100;
        b1 = (got_q.size() > base + 1) ? {1'b0, got_q[base + 1]} : 9'h100;
        check("b2b_count", got_q.size() - base, 2);
        check("b2b_first", b0, 9'h000);
        check("b2b_second", b1, 9'h0FF);
        check("b2b_ferr",  ferr_hi - f0, 0);

        // Reset in the middle of bit 4 of 0x55
        v0 = valid_hi; f0 = ferr_hi;
        drive_frame({1'b1, 8'h55, 1'b0}, 5 * BIT + BIT / 2);
        check("mid_busy", busy, 1'b1);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge sys_clk);
        rst = 1'b0;
        check("rst_abort_busy", busy, 1'b0);
        repeat (2 * BIT) @(negedge sys_clk);
        check("rst_abort_valid", valid_hi - v0, 0);
        check("rst_abort_ferr",  ferr_hi - f0,  0);
        check("rst_abort_data",  data_out,      8'h00);
        v0 = valid_hi;
        drive_frame({1'b1, 8'h81, 1'b0}, 10 * BIT);
        repeat (4) @(negedge sys_clk);
        check("post_rst_data",  data_out,      8'h81);
        check("post_rst_valid", valid_hi - v0, 1);

        // Frame as a TX block would emit it for data_in 0xC3
        v0 = valid_hi;
        drive_frame({1'b1, 8'hC3, 1'b0}, 10 * BIT);
        repeat (BIT) @(negedge sys_clk);
        check("loop_data",  data_out,      8'hC3);
        check("loop_valid", valid_hi - v0, 1);

        check("never_both", both_hi, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
